cpu_mem_responder: RTL

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder.sv | 99 +++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// Dual-port (instruction/data) word memory with a self-clearing INIT phase and byte write enables.
// Optional build macro MEM_OOR_ERR_EN enables out-of-range access detection with a sticky oor_err flag.
module cpu_mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_en,
  input  logic [3:0]  inst_we,
  output logic [31:0] inst_rdata,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_en,
  input  logic [3:0]  data_we,
  output logic [31:0] data_rdata,
  output logic        init_done,
  output logic        oor_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic            oor_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   inst_idx;
  logic [AW-1:0]   data_idx;
  logic            inst_oor;
  logic            data_oor;
  logic            inst_wr;
  logic            data_wr;
  logic            unused_addr_bits;

  assign inst_idx = inst_addr[AW+1:2];
  assign data_idx = data_addr[AW+1:2];

`ifdef MEM_OOR_ERR_EN
  assign inst_oor = (inst_addr[31:AW+2] != '0);
  assign data_oor = (data_addr[31:AW+2] != '0);
  assign unused_addr_bits = ^{inst_addr[1:0], data_addr[1:0]};
`else
  // Upper address bits are dropped so accesses wrap modulo the depth.
  assign inst_oor = 1'b0;
  assign data_oor = 1'b0;
  assign unused_addr_bits = ^{inst_addr[31:AW+2], inst_addr[1:0],
                              data_addr[31:AW+2], data_addr[1:0]};
`endif

  assign inst_wr   = (state == READY) && inst_en && !inst_oor;
  assign data_wr   = (state == READY) && data_en && !data_oor;
  assign init_done = (state == READY);
  assign oor_err   = oor_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= INIT;
      clr_cnt    <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      oor_q      <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= READY;
        end
        READY: begin
          // Reads sample the array before this edge's writes land: read-first on both ports.
          if (inst_en) inst_rdata <= inst_oor ? '0 : mem[inst_idx];
          if (data_en) data_rdata <= data_oor ? '0 : mem[data_idx];
          if ((inst_en && inst_oor) || (data_en && data_oor)) oor_q <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: the array has no reset branch; it is zeroed word by word during INIT instead.
  always_ff @(posedge aclk) begin
    if (state == INIT) begin
      if (aresetn) mem[clr_cnt] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        // Data port is applied last so it owns any byte both ports write.
        if (inst_wr && inst_we[b]) mem[inst_idx][8*b +: 8] <= inst_wdata[8*b +: 8];
        if (data_wr && data_we[b]) mem[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

endmodule
